// File: rtl/mixed_block_c_arbiter.sv
// mixed_block_c_arbiter
// Round-robin burst arbiter that shares one block-C output channel among
// NUM_REQ requesters. Each granted burst is preceded by one 13-bit header
// beat {grant[1:0], seq[7:0], 3'b101}. Payload beats are 5-bit seeSt values
// {variablec2[2:0], variablec[1:0]} and are zero-extended to 13 bits.
//
// Optional feature: define MIXED_BLOCK_C_ARB_MAXBURST_EN to cap every grant
// at MAX_BURST payload beats. Without the macro, a burst ends only on req_last.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-high
//   req_valid  per-requester payload valid            [NUM_REQ]
//   req_data   per-requester seeSt, slice i = [5i+4:5i] [NUM_REQ*5]
//   req_last   per-requester final beat of the burst   [NUM_REQ]
//   req_ready  per-requester accept                    [NUM_REQ]
//   out_valid  output beat valid
//   out_is_hdr 1 = header beat, 0 = payload beat
//   out_data   header, or {8'b0, seeSt}                [13]
//   out_last   final payload beat (0 on header beats)
//   out_ready  downstream accept
//   busy       arbiter is not idle
//   cur_src    currently granted requester             [2]
module mixed_block_c_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*5-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic                 out_is_hdr,
  output logic [12:0]          out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [1:0]           cur_src
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} stateT;

  stateT       stateReg;
  logic [1:0]  grantReg;
  logic [1:0]  lastGrantReg;
  logic [7:0]  seqReg;
  logic [12:0] hdrReg;

  logic [4:0]  seeArr [NUM_REQ];
  logic [1:0]  winner;
  logic        reqValidG;
  logic        reqLastG;
  logic        burstEnd;

  // Unpack the flat payload bus so the granted slice can be picked by index.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign seeArr[gi] = req_data[5*gi +: 5];
    end
  endgenerate

  assign reqValidG = req_valid[grantReg];
  assign reqLastG  = req_last[grantReg];

`ifdef MIXED_BLOCK_C_ARB_MAXBURST_EN
  logic [7:0] beatCntReg;
  // True on the beat that would be the MAX_BURST-th transfer of this grant.
  assign burstEnd = (beatCntReg == 8'(MAX_BURST - 1));
`else
  assign burstEnd = 1'b0;
`endif

  // Round-robin search starting one past the previous winner, with wrap.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found  = 1'b0;
    idx    = '0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(lastGrantReg) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Header beats come from registers; payload beats pass straight through
  // from the granted requester so there is no bubble inside a burst.
  always_comb begin
    out_valid  = 1'b0;
    out_is_hdr = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    req_ready  = '0;
    case (stateReg)
      HDR: begin
        out_valid  = 1'b1;
        out_is_hdr = 1'b1;
        out_data   = hdrReg;
      end
      DATA: begin
        out_valid           = reqValidG;
        out_data            = {8'b0, seeArr[grantReg]};
        out_last            = reqLastG | burstEnd;
        req_ready[grantReg] = out_ready;
      end
      default: ;
    endcase
  end

  assign busy    = (stateReg != IDLE);
  assign cur_src = grantReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg     <= IDLE;
      grantReg     <= '0;
      lastGrantReg <= 2'(NUM_REQ - 1);
      seqReg       <= '0;
      hdrReg       <= '0;
`ifdef MIXED_BLOCK_C_ARB_MAXBURST_EN
      beatCntReg   <= '0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          if (|req_valid) begin
            grantReg     <= winner;
            lastGrantReg <= winner;
            hdrReg       <= {winner, seqReg, 3'b101};
            stateReg     <= HDR;
          end
        end
        HDR: begin
          if (out_ready) begin
            seqReg     <= seqReg + 8'd1;
            stateReg   <= DATA;
`ifdef MIXED_BLOCK_C_ARB_MAXBURST_EN
            beatCntReg <= '0;
`endif
          end
        end
        DATA: begin
          if (reqValidG && out_ready) begin
`ifdef MIXED_BLOCK_C_ARB_MAXBURST_EN
            beatCntReg <= beatCntReg + 8'd1;
`endif
            if (reqLastG || burstEnd) stateReg <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mixed_block_c_arbiter.sv
// Self-checking bench for mixed_block_c_arbiter: a table of per-cycle
// vectors for a single burst and a round-robin pass, then hand-written
// sequences for backpressure, reset mid-burst, long/capped bursts and
// sequence-number wrap.
module tb_mixed_block_c_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid;
  logic [19:0] reqData;
  logic [3:0]  reqLast;
  logic [3:0]  reqReady;
  logic        outValid;
  logic        outIsHdr;
  logic [12:0] outData;
  logic        outLast;
  logic        outReady;
  logic        busy;
  logic [1:0]  curSrc;

  int nChecks = 0;
  int nFail   = 0;
  logic [7:0] tbSeq;

  always #5 clk = ~clk;

  mixed_block_c_arbiter #(.NUM_REQ(4), .MAX_BURST(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_data(reqData), .req_last(reqLast),
    .req_ready(reqReady),
    .out_valid(outValid), .out_is_hdr(outIsHdr), .out_data(outData),
    .out_last(outLast), .out_ready(outReady),
    .busy(busy), .cur_src(curSrc)
  );

  typedef struct {
    logic [3:0]  v;
    logic [19:0] d;
    logic [3:0]  l;
    logic        rdy;
    logic        eV;
    logic        eH;
    logic [12:0] eD;
    logic        eL;
    logic [3:0]  eR;
    logic        eB;
    logic [1:0]  eS;
  } vecT;

  vecT tbl[$];

  function automatic vecT mk(logic [3:0] v, logic [19:0] d, logic [3:0] l, logic rdy,
                             logic eV, logic eH, logic [12:0] eD, logic eL,
                             logic [3:0] eR, logic eB, logic [1:0] eS);
    vecT t;
    t.v = v; t.d = d; t.l = l; t.rdy = rdy;
    t.eV = eV; t.eH = eH; t.eD = eD; t.eL = eL; t.eR = eR; t.eB = eB; t.eS = eS;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dataFor(input int src, input int b);
    return 5'((src * 7 + b * 3 + 1) & 31);
  endfunction

  // One burst from one requester with out_ready held high. The requester
  // raises req_last on the final beat only when reqLastAtEnd is set; the
  // output must flag the final beat of this grant either way.
  task automatic runBurst(input int src, input int nBeats, input int firstBeat,
                          input bit reqLastAtEnd);
    bit seen;
    logic [1:0] s;
    s = src[1:0];
    @(negedge clk);
    reqValid = 4'b0001 << src;
    reqData = '0;
    reqData[5*src +: 5] = dataFor(src, firstBeat);
    reqLast = '0;
    if (nBeats == 1 && reqLastAtEnd) reqLast[src] = 1'b1;
    outReady = 1'b1;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (outValid && outIsHdr) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("burst hdr seen", 32'(seen), 32'd1);
    if (seen) begin
      check("burst hdr data", 32'(outData), 32'({s, tbSeq, 3'b101}));
      check("burst hdr src", 32'(curSrc), 32'(s));
      tbSeq = tbSeq + 8'd1;
      for (int b = 0; b < nBeats; b++) begin
        @(negedge clk);
        reqData = '0;
        reqData[5*src +: 5] = dataFor(src, firstBeat + b);
        reqLast = '0;
        if (b == nBeats - 1 && reqLastAtEnd) reqLast[src] = 1'b1;
        #1;
        check("burst beat valid", 32'(outValid && !outIsHdr), 32'd1);
        check("burst beat data", 32'(outData), 32'({8'b0, dataFor(src, firstBeat + b)}));
        check("burst beat last", 32'(outLast), 32'(b == nBeats - 1));
        check("burst beat ready", 32'(reqReady), 32'(4'b0001 << src));
      end
    end
    @(negedge clk);
    reqValid = '0;
    reqLast  = '0;
    #1;
    check("burst end idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reqValid = '0; reqData = '0; reqLast = '0; outReady = 1'b0;
    tbSeq = '0;

    // Single burst from requester 0, then a full round-robin pass.
    tbl.push_back(mk(4'b0001, 20'h00011, 4'b0000, 1, 0, 0, 13'h000, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(4'b0001, 20'h00011, 4'b0000, 1, 1, 1, 13'h005, 0, 4'b0000, 1, 2'd0));
    tbl.push_back(mk(4'b0001, 20'h00011, 4'b0000, 1, 1, 0, 13'h011, 0, 4'b0001, 1, 2'd0));
    tbl.push_back(mk(4'b0001, 20'h00002, 4'b0000, 1, 1, 0, 13'h002, 0, 4'b0001, 1, 2'd0));
    tbl.push_back(mk(4'b0001, 20'h0001F, 4'b0001, 1, 1, 0, 13'h01F, 1, 4'b0001, 1, 2'd0));
    tbl.push_back(mk(4'b0000, 20'h00000, 4'b0000, 1, 0, 0, 13'h000, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 0, 0, 13'h000, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 1, 13'h080D, 0, 4'b0000, 1, 2'd1));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 0, 13'h009, 1, 4'b0010, 1, 2'd1));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 0, 0, 13'h000, 0, 4'b0000, 0, 2'd1));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 1, 13'h1015, 0, 4'b0000, 1, 2'd2));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 0, 13'h00A, 1, 4'b0100, 1, 2'd2));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 0, 0, 13'h000, 0, 4'b0000, 0, 2'd2));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 1, 13'h181D, 0, 4'b0000, 1, 2'd3));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 0, 13'h00B, 1, 4'b1000, 1, 2'd3));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 0, 0, 13'h000, 0, 4'b0000, 0, 2'd3));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 1, 13'h025, 0, 4'b0000, 1, 2'd0));
    tbl.push_back(mk(4'b1111, {5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b1111, 1, 1, 0, 13'h008, 1, 4'b0001, 1, 2'd0));
    tbl.push_back(mk(4'b0000, 20'h00000, 4'b0000, 1, 0, 0, 13'h000, 0, 4'b0000, 0, 2'd0));

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset out_valid", 32'(outValid), 32'd0);
    check("reset out_is_hdr", 32'(outIsHdr), 32'd0);
    check("reset out_data", 32'(outData), 32'd0);
    check("reset out_last", 32'(outLast), 32'd0);
    check("reset req_ready", 32'(reqReady), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset cur_src", 32'(curSrc), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reqValid = tbl[i].v; reqData = tbl[i].d; reqLast = tbl[i].l; outReady = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(outValid), 32'(tbl[i].eV));
      check($sformatf("vec%0d out_is_hdr", i), 32'(outIsHdr), 32'(tbl[i].eH));
      check($sformatf("vec%0d out_data", i), 32'(outData), 32'(tbl[i].eD));
      check($sformatf("vec%0d out_last", i), 32'(outLast), 32'(tbl[i].eL));
      check($sformatf("vec%0d req_ready", i), 32'(reqReady), 32'(tbl[i].eR));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].eB));
      check($sformatf("vec%0d cur_src", i), 32'(curSrc), 32'(tbl[i].eS));
    end

    // Backpressure on requester 2: stalled header, stalled data, valid gap.
    @(negedge clk);
    reqValid = 4'b0100; reqData = '0; reqData[14:10] = 5'h05; reqLast = '0; outReady = 1'b0;
    #1;
    check("bp idle busy", 32'(busy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp hdr held", 32'(outData), 32'h102D);
      check("bp hdr valid", 32'(outValid && outIsHdr), 32'd1);
      check("bp hdr req_ready", 32'(reqReady), 32'd0);
    end
    @(negedge clk);
    outReady = 1'b1;
    #1;
    check("bp hdr release", 32'(outData), 32'h102D);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      outReady = 1'b0;
      #1;
      check("bp data stall valid", 32'(outValid && !outIsHdr), 32'd1);
      check("bp data stall data", 32'(outData), 32'h005);
      check("bp data stall ready", 32'(reqReady), 32'd0);
    end
    @(negedge clk);
    reqValid = 4'b0000; outReady = 1'b1;
    #1;
    check("bp gap valid", 32'(outValid), 32'd0);
    check("bp gap busy", 32'(busy), 32'd1);
    check("bp gap src", 32'(curSrc), 32'd2);
    @(negedge clk);
    reqValid = 4'b0100;
    #1;
    check("bp beat0 data", 32'(outData), 32'h005);
    check("bp beat0 last", 32'(outLast), 32'd0);
    check("bp beat0 ready", 32'(reqReady), 32'h4);
    @(negedge clk);
    reqData[14:10] = 5'h16; reqLast = 4'b0100;
    #1;
    check("bp beat1 data", 32'(outData), 32'h016);
    check("bp beat1 last", 32'(outLast), 32'd1);
    @(negedge clk);
    reqValid = '0; reqLast = '0;
    #1;
    check("bp done busy", 32'(busy), 32'd0);

    // Reset in the middle of a 4-beat burst from requester 3.
    @(negedge clk);
    reqValid = 4'b1000; reqData = '0; reqData[19:15] = 5'h03; reqLast = '0; outReady = 1'b1;
    #1;
    check("rst idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("rst hdr data", 32'(outData), 32'h1835);
    check("rst hdr src", 32'(curSrc), 32'd3);
    @(negedge clk);
    #1;
    check("rst beat0", 32'(outData), 32'h003);
    @(negedge clk);
    reqData[19:15] = 5'h04;
    #1;
    check("rst beat1", 32'(outData), 32'h004);
    @(negedge clk);
    reqData[19:15] = 5'h05;
    #1;
    check("rst beat2 busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst async busy", 32'(busy), 32'd0);
    check("rst async valid", 32'(outValid), 32'd0);
    check("rst async ready", 32'(reqReady), 32'd0);
    check("rst async src", 32'(curSrc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reqValid = 4'b1111; reqData = {5'h0B, 5'h0A, 5'h09, 5'h08}; reqLast = 4'b1111;
    #1;
    check("rst after idle", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("rst after hdr", 32'(outData), 32'h005);
    check("rst after src", 32'(curSrc), 32'd0);
    @(negedge clk);
    #1;
    check("rst after beat", 32'(outData), 32'h008);
    check("rst after ready", 32'(reqReady), 32'd1);
    @(negedge clk);
    reqValid = '0; reqLast = '0;
    #1;
    check("rst after done", 32'(busy), 32'd0);
    tbSeq = 8'd1;

`ifdef MIXED_BLOCK_C_ARB_MAXBURST_EN
    // Five beats from requester 1 split into grants of 2, 2 and 1.
    runBurst(1, 2, 0, 1'b0);
    runBurst(1, 2, 2, 1'b0);
    runBurst(1, 1, 4, 1'b1);
`else
    // Without the cap a long burst is never split.
    runBurst(1, 10, 0, 1'b1);
`endif

    // Enough one-beat bursts that the 8-bit sequence number wraps to 0.
    for (int n = 0; n < 256; n++) runBurst(0, 1, n, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
